// File: rtl/eth_rx_if.sv
// eth_rx_if: received-byte stream and frame status from the Manchester receiver.
// master drives the stream (the receiver), slave consumes it.
interface eth_rx_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sof;
   logic        rx_eof;
   logic        rx_crc_ok;
   logic [10:0] rx_len;
   logic        rx_active;

   modport master (
      output rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_len, rx_active
   );

   modport slave (
      input rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_len, rx_active
   );
endinterface

// File: rtl/eth_rx.sv
// eth_rx: 10BASE-T Manchester receiver at 8 clk per bit. Recovers bits from
// mid-bit edges, hunts preamble/SFD, emits bytes and checks the Ethernet FCS.
module eth_rx (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     rx_eth,
   eth_rx_if.master bus
);

   localparam int unsigned LEN_W   = 11;
   localparam int unsigned CRC_W   = 32;
   localparam int unsigned SIL_W   = 5;
   localparam int unsigned BLANK_W = 3;

   localparam logic [CRC_W-1:0]   CRC_POLY    = 32'hEDB8_8320;
   localparam logic [CRC_W-1:0]   CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [CRC_W-1:0]   CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [LEN_W-1:0]   LEN_MAX     = 11'd2047;
   localparam logic [LEN_W-1:0]   LEN_MIN_OK  = 11'd64;
   localparam logic [LEN_W-1:0]   LEN_MAX_OK  = 11'd1518;
   localparam logic [SIL_W-1:0]   SIL_LOSS    = 5'd16;
   localparam logic [SIL_W-1:0]   SIL_SAT     = 5'd31;
   localparam logic [BLANK_W-1:0] BLANK_CLKS  = 3'd6;

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   // line decoder
   logic [1:0]         sync_q;
   logic               lvl_q;
   logic [BLANK_W-1:0] blank_q;
   logic [SIL_W-1:0]   sil_q;

   logic edge_c, mid_c, lost_c, bit_c;
   assign edge_c = sync_q[1] ^ lvl_q;
   assign mid_c  = edge_c && (blank_q == '0);
   assign lost_c = (sil_q == SIL_LOSS);
   assign bit_c  = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         lvl_q   <= 1'b0;
         blank_q <= '0;
         sil_q   <= '0;
      end else begin
         sync_q <= {sync_q[0], rx_eth};
         lvl_q  <= sync_q[1];
         // a mid-bit edge opens a 3/4-bit window that swallows the boundary edge
         if (mid_c)
            blank_q <= BLANK_CLKS;
         else if (blank_q != '0)
            blank_q <= blank_q - 3'd1;
         if (edge_c)
            sil_q <= '0;
         else if (sil_q != SIL_SAT)
            sil_q <= sil_q + 5'd1;
      end
   end

   // framer state and datapath
   state_t           state_q, state_d;
   logic [7:0]       sr_q, sr_d;
   logic [3:0]       alt_q, alt_d;
   logic [2:0]       bitcnt_q, bitcnt_d;
   logic [CRC_W-1:0] crc_q, crc_d;
   logic             crc_good_q, crc_good_d;
   logic             first_q, first_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             sof_q, sof_d;
   logic             eof_q, eof_d;
   logic             ok_q, ok_d;
   logic             active_q, active_d;

   logic [7:0]       sr_shift_c;
   logic [CRC_W-1:0] crc_nx_c;
   assign sr_shift_c = {bit_c, sr_q[7:1]};
   assign crc_nx_c   = {1'b0, crc_q[CRC_W-1:1]} ^ ((crc_q[0] ^ bit_c) ? CRC_POLY : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         alt_q      <= '0;
         bitcnt_q   <= '0;
         crc_q      <= CRC_INIT;
         crc_good_q <= 1'b0;
         first_q    <= 1'b0;
         len_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         ok_q       <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         alt_q      <= alt_d;
         bitcnt_q   <= bitcnt_d;
         crc_q      <= crc_d;
         crc_good_q <= crc_good_d;
         first_q    <= first_d;
         len_q      <= len_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         ok_q       <= ok_d;
         active_q   <= active_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      alt_d      = alt_q;
      bitcnt_d   = bitcnt_q;
      crc_d      = crc_q;
      crc_good_d = crc_good_q;
      first_d    = first_q;
      len_d      = len_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      ok_d       = 1'b0;
      // lags the state by one clk so it is still high alongside rx_eof
      active_d   = (state_q == PREAMBLE) || (state_q == DATA);

      case (state_q)
         IDLE: begin
            if (mid_c) begin
               state_d = PREAMBLE;
               sr_d    = {bit_c, 7'd0};
               alt_d   = '0;
            end
         end
         PREAMBLE: begin
            if (lost_c) begin
               state_d = IDLE;
            end else if (mid_c) begin
               sr_d = sr_shift_c;
               if (bit_c != sr_q[7]) begin
                  if (alt_q != 4'hF) alt_d = alt_q + 4'd1;
               end else if ((sr_shift_c == 8'hD5) && (alt_q >= 4'd8)) begin
                  state_d    = DATA;
                  bitcnt_d   = '0;
                  crc_d      = CRC_INIT;
                  crc_good_d = 1'b0;
                  first_d    = 1'b1;
                  len_d      = '0;
               end else begin
                  state_d = DROP;
               end
            end
         end
         DATA: begin
            if (lost_c) begin
               // dribble bits after the last whole byte are dropped silently
               eof_d   = 1'b1;
               ok_d    = crc_good_q && (len_q >= LEN_MIN_OK) && (len_q <= LEN_MAX_OK);
               state_d = IDLE;
            end else if (mid_c) begin
               sr_d     = sr_shift_c;
               crc_d    = crc_nx_c;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  valid_d    = 1'b1;
                  sof_d      = first_q;
                  first_d    = 1'b0;
                  data_d     = sr_shift_c;
                  crc_good_d = (crc_nx_c == CRC_RESIDUE);
                  if (len_q != LEN_MAX) len_d = len_q + 11'd1;
               end
            end
         end
         DROP: begin
            if (lost_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.rx_sof    = sof_q;
   assign bus.rx_eof    = eof_q;
   assign bus.rx_crc_ok = ok_q;
   assign bus.rx_len    = len_q;
   assign bus.rx_active = active_q;

endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: drives Manchester frames into eth_rx from a table of scenarios
// plus reset-abort and back-to-back sequences; checks bytes and frame status.
module tb_eth_rx;

   logic clk;
   logic rst_n;
   logic rx_eth;

   eth_rx_if bus ();

   eth_rx dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_eth(rx_eth),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;   // 8 clk per bit => nominal half bit is 400

   int checks = 0;
   int errors = 0;

   logic [7:0] tx_bytes [2048];
   logic [7:0] mon_data [2048];
   int mon_valid, mon_sof, mon_sof_first, mon_eof, mon_len, mon_ok, mon_ok_cnt;
   int mon_act_at_eof, mon_act_after;
   bit act_pend;

   typedef struct {
      int n_pay;
      int flip;      // payload bit index to corrupt after FCS, -1 none
      int dribble;
      bit dbl_pre;
      int hb;        // half-bit time (skew)
      int exp_valid;
      int exp_eof;
      int exp_len;
      int exp_ok;
   } vec_t;

   // capture stream outputs away from the active edge
   always @(negedge clk) begin
      if (act_pend) begin
         mon_act_after = int'(bus.rx_active);
         act_pend = 1'b0;
      end
      if (bus.rx_valid) begin
         if (mon_valid < 2048) mon_data[mon_valid] = bus.rx_data;
         if (bus.rx_sof && mon_valid == 0) mon_sof_first++;
         mon_valid++;
      end
      if (bus.rx_sof) mon_sof++;
      if (bus.rx_eof) begin
         mon_eof++;
         mon_len = int'(bus.rx_len);
         mon_ok  = int'(bus.rx_crc_ok);
         if (bus.rx_crc_ok) mon_ok_cnt++;
         mon_act_at_eof = int'(bus.rx_active);
         act_pend = 1'b1;
      end
   end

   task automatic clear_mon();
      mon_valid = 0; mon_sof = 0; mon_sof_first = 0; mon_eof = 0;
      mon_len = -1; mon_ok = -1; mon_ok_cnt = 0;
      mon_act_at_eof = -1; mon_act_after = -1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in;
      for (int k = 0; k < 8; k++)
         c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   task automatic send_bit(input logic b, input int hb);
      rx_eth = ~b;
      #(hb);
      rx_eth = b;
      #(hb);
   endtask

   task automatic send_byte(input logic [7:0] v, input int hb);
      for (int k = 0; k < 8; k++) send_bit(v[k], hb);
   endtask

   task automatic send_frame(input int n_pay, input int flip, input int dribble,
                             input bit dbl_pre, input int hb, input int abort_after);
      logic [31:0] c;
      logic [7:0]  t;
      int n;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n_pay; i++) begin
         tx_bytes[i] = 8'(i * 29 + 7);
         c = crc_byte(c, tx_bytes[i]);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) tx_bytes[n_pay + k] = c[8*k +: 8];
      n = n_pay + 4;
      if (flip >= 0) begin
         t = tx_bytes[flip / 8];
         t[flip % 8] = ~t[flip % 8];
         tx_bytes[flip / 8] = t;
      end
      for (int i = 0; i < 56; i++) begin
         send_bit((i % 2 == 0) ? 1'b1 : 1'b0, hb);
         if (dbl_pre && i == 21) send_bit(1'b0, hb);
      end
      send_byte(8'hD5, hb);
      for (int i = 0; i < n; i++) begin
         if (i == abort_after) return;
         send_byte(tx_bytes[i], hb);
      end
      for (int i = 0; i < dribble; i++) send_bit((i % 2 == 0) ? 1'b1 : 1'b0, hb);
      rx_eth = 1'b0;
   endtask

   function automatic int out_vec();
      return 32'({bus.rx_data, bus.rx_valid, bus.rx_sof, bus.rx_eof,
                  bus.rx_crc_ok, bus.rx_len, bus.rx_active});
   endfunction

   initial begin
      vec_t vecs [6];
      int derr;

      vecs[0] = '{n_pay:60, flip:-1, dribble:0, dbl_pre:0, hb:400, exp_valid:64, exp_eof:1, exp_len:64, exp_ok:1};
      vecs[1] = '{n_pay:60, flip:83, dribble:0, dbl_pre:0, hb:400, exp_valid:64, exp_eof:1, exp_len:64, exp_ok:0};
      vecs[2] = '{n_pay:60, flip:-1, dribble:3, dbl_pre:0, hb:400, exp_valid:64, exp_eof:1, exp_len:64, exp_ok:1};
      vecs[3] = '{n_pay:60, flip:-1, dribble:0, dbl_pre:1, hb:400, exp_valid:0,  exp_eof:0, exp_len:0,  exp_ok:0};
      vecs[4] = '{n_pay:60, flip:-1, dribble:0, dbl_pre:0, hb:404, exp_valid:64, exp_eof:1, exp_len:64, exp_ok:1};
      vecs[5] = '{n_pay:59, flip:-1, dribble:0, dbl_pre:0, hb:396, exp_valid:63, exp_eof:1, exp_len:63, exp_ok:0};

      rx_eth = 1'b0;
      rst_n  = 1'b0;
      act_pend = 1'b0;
      clear_mon();
      #517;
      check("reset_outputs", out_vec(), 0);
      @(negedge clk) rst_n = 1'b1;
      #2000;
      check("idle_outputs", out_vec(), 0);

      for (int v = 0; v < 6; v++) begin
         clear_mon();
         #(37 + v * 13);
         send_frame(vecs[v].n_pay, vecs[v].flip, vecs[v].dribble, vecs[v].dbl_pre, vecs[v].hb, -1);
         #(40 * 800);
         check($sformatf("v%0d_valid", v), mon_valid, vecs[v].exp_valid);
         check($sformatf("v%0d_eof", v), mon_eof, vecs[v].exp_eof);
         check($sformatf("v%0d_sof", v), mon_sof, (vecs[v].exp_valid > 0) ? 1 : 0);
         if (vecs[v].exp_valid > 0) begin
            derr = 0;
            for (int i = 0; i < vecs[v].exp_valid; i++)
               if (mon_data[i] != tx_bytes[i]) derr++;
            check($sformatf("v%0d_sof_first", v), mon_sof_first, 1);
            check($sformatf("v%0d_data_errs", v), derr, 0);
         end
         if (vecs[v].exp_eof > 0) begin
            check($sformatf("v%0d_len", v), mon_len, vecs[v].exp_len);
            check($sformatf("v%0d_crc_ok", v), mon_ok, vecs[v].exp_ok);
            check($sformatf("v%0d_active_fall", v), mon_act_at_eof * 2 + mon_act_after, 2);
         end
      end

      // reset pulsed mid-frame after 20 bytes
      clear_mon();
      #41;
      send_frame(60, -1, 0, 0, 400, 20);
      #300;
      check("abort_valid_before_rst", mon_valid, 20);
      rst_n = 1'b0;
      #1;
      check("abort_outputs_zero", out_vec(), 0);
      rx_eth = 1'b0;
      #1000;
      @(negedge clk) rst_n = 1'b1;
      #(40 * 800);
      check("abort_no_eof", mon_eof, 0);
      check("abort_no_more_valid", mon_valid, 20);
      clear_mon();
      send_frame(60, -1, 0, 0, 400, -1);
      #(40 * 800);
      check("after_rst_eof", mon_eof, 1);
      check("after_rst_len", mon_len, 64);
      check("after_rst_crc_ok", mon_ok, 1);

      // two frames 12 bit times apart, +1% then -1% line clock
      clear_mon();
      #23;
      send_frame(60, -1, 0, 0, 404, -1);
      #(12 * 2 * 404);
      send_frame(60, -1, 0, 0, 396, -1);
      #(40 * 800);
      check("b2b_eof", mon_eof, 2);
      check("b2b_crc_ok", mon_ok_cnt, 2);
      check("b2b_valid", mon_valid, 128);
      check("b2b_sof", mon_sof, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
